// File: rtl/ecc_load_pipe.sv
// ecc_load_pipe: two-stage SECDED load-return pipe with valid/ready flow control
// and saturating SEC/DED event counters. Special loads bypass correction.
// Optional build macro ECC_LOAD_POISON_EN adds rsp_poison and forces DED data to all ones.
module ecc_load_pipe #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned PAR_W  = 7,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_data,
  input  logic [PAR_W-1:0]  req_parity,
  input  logic              req_special,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_sec,
  output logic              rsp_ded,
`ifdef ECC_LOAD_POISON_EN
  output logic              rsp_poison,
`endif
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  sec_count,
  output logic [CNT_W-1:0]  ded_count
);

  localparam int unsigned HAM_W  = PAR_W - 1;
  localparam int unsigned CW_TOP = DATA_W + PAR_W - 1;

`ifdef ECC_LOAD_POISON_EN
  localparam bit POISON_EN = 1'b1;
`else
  localparam bit POISON_EN = 1'b0;
`endif

  // Codeword position of data bit idx: non-power-of-two positions in ascending order.
  function automatic logic [HAM_W-1:0] data_pos(input int unsigned idx);
    logic [HAM_W-1:0] pos;
    int unsigned      seen;
    pos  = '0;
    seen = 0;
    for (int unsigned q = 3; q <= CW_TOP; q++) begin
      if ((q & (q - 1)) != 0) begin
        if (seen == idx) pos = HAM_W'(q);
        seen = seen + 1;
      end
    end
    return pos;
  endfunction

  logic              s1_valid;
  logic [DATA_W-1:0] s1_data;
  logic              s1_special;
  logic [HAM_W-1:0]  s1_syn;
  logic              s1_ovr;

  logic [HAM_W-1:0]  syn_c;
  logic              ovr_c;
  logic              s2_hold;
  logic              s1_advance;
  logic              rsp_fire;

  logic [DATA_W-1:0] dec_data;
  logic              dec_sec;
  logic              dec_ded;

  // Flow control: S2 holds on a stalled response, S1 moves when S2 is empty or draining.
  always_comb begin
    s2_hold    = rsp_valid && !rsp_ready;
    s1_advance = s1_valid && !s2_hold;
    req_ready  = !s1_valid || s1_advance;
    rsp_fire   = rsp_valid && rsp_ready;
  end

  // Syndrome and overall parity of the incoming word.
  always_comb begin
    syn_c = req_parity[HAM_W-1:0];
    ovr_c = ^{req_data, req_parity};
    for (int unsigned j = 0; j < DATA_W; j++) begin
      if (req_data[j]) syn_c = syn_c ^ data_pos(j);
    end
  end

  // Stage 1: capture request with its syndrome.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_data    <= '0;
      s1_special <= 1'b0;
      s1_syn     <= '0;
      s1_ovr     <= 1'b0;
    end else if (req_ready) begin
      s1_valid <= req_valid;
      if (req_valid) begin
        s1_data    <= req_data;
        s1_special <= req_special;
        s1_syn     <= syn_c;
        s1_ovr     <= ovr_c;
      end
    end
  end

  // Decode S1 syndrome into corrected data and SEC/DED flags.
  always_comb begin
    dec_data = s1_data;
    dec_sec  = 1'b0;
    dec_ded  = 1'b0;
    if (!s1_special) begin
      if (s1_ovr) begin
        if (32'(s1_syn) > 32'(CW_TOP)) begin
          dec_ded = 1'b1;
        end else begin
          dec_sec = 1'b1;
          for (int unsigned j = 0; j < DATA_W; j++) begin
            if (s1_syn == data_pos(j)) dec_data[j] = ~s1_data[j];
          end
        end
      end else if (s1_syn != '0) begin
        dec_ded = 1'b1;
      end
    end
    if (POISON_EN && dec_ded) dec_data = '1;
  end

  // Stage 2: response register, frozen while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_sec   <= 1'b0;
      rsp_ded   <= 1'b0;
    end else if (!s2_hold) begin
      rsp_valid <= s1_valid;
      if (s1_valid) begin
        rsp_data <= dec_data;
        rsp_sec  <= dec_sec;
        rsp_ded  <= dec_ded;
      end
    end
  end

`ifdef ECC_LOAD_POISON_EN
  // Poison flag tracks the DED flag of the response register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_poison <= 1'b0;
    end else if (!s2_hold && s1_valid) begin
      rsp_poison <= dec_ded;
    end
  end
`endif

  // Saturating event counters, counted on the response handshake; clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec_count <= '0;
      ded_count <= '0;
    end else if (clr_cnt) begin
      sec_count <= '0;
      ded_count <= '0;
    end else if (rsp_fire) begin
      if (rsp_sec && (sec_count != '1)) sec_count <= sec_count + CNT_W'(1);
      if (rsp_ded && (ded_count != '1)) ded_count <= ded_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ecc_load_pipe.sv
// Randomized self-checking bench for ecc_load_pipe with a codeword-level reference model.
module tb_ecc_load_pipe;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned PAR_W  = 7;
  localparam int unsigned CNT_W  = 8;
  localparam int          CW_TOP = DATA_W + PAR_W - 1;
  localparam int          UNITS  = DATA_W + PAR_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [DATA_W-1:0] req_data = '0;
  logic [PAR_W-1:0]  req_parity = '0;
  logic              req_special = 1'b0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b1;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_sec;
  logic              rsp_ded;
`ifdef ECC_LOAD_POISON_EN
  logic              rsp_poison;
`endif
  logic              clr_cnt = 1'b0;
  logic [CNT_W-1:0]  sec_count;
  logic [CNT_W-1:0]  ded_count;

  ecc_load_pipe #(.DATA_W(DATA_W), .PAR_W(PAR_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_data   (req_data),
    .req_parity (req_parity),
    .req_special(req_special),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_sec    (rsp_sec),
    .rsp_ded    (rsp_ded),
`ifdef ECC_LOAD_POISON_EN
    .rsp_poison (rsp_poison),
`endif
    .clr_cnt    (clr_cnt),
    .sec_count  (sec_count),
    .ded_count  (ded_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              sec;
    logic              ded;
    int                acc_cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   n_rsp = 0;
  int   m_sec = 0;
  int   m_ded = 0;
  bit   check_lat = 1'b0;
  bit   stalled = 1'b0;
  bit   saw_not_ready = 1'b0;
  logic [DATA_W-1:0] held_data = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Position of data bit j in the codeword (skip powers of two).
  function automatic int pos_of(input int j);
    int n = 0;
    for (int q = 1; q < 64; q++) begin
      if ((q & (q - 1)) != 0) begin
        if (n == j) return q;
        n++;
      end
    end
    return 0;
  endfunction

  function automatic logic [PAR_W-1:0] encode(input logic [DATA_W-1:0] d);
    logic [PAR_W-1:0] p = '0;
    for (int i = 0; i < PAR_W - 1; i++)
      for (int j = 0; j < DATA_W; j++)
        if (d[j] && ((pos_of(j) >> i) & 1) == 1) p[i] = ~p[i];
    p[PAR_W-1] = ^{d, p[PAR_W-2:0]};
    return p;
  endfunction

  // Reference decode: lay out the full codeword, XOR set positions for the syndrome.
  function automatic exp_t model(input logic [DATA_W-1:0] d, input logic [PAR_W-1:0] p,
                                 input logic sp);
    exp_t e;
    logic [63:0] cw = '0;
    int s = 0;
    logic o;
    e.data = d; e.sec = 1'b0; e.ded = 1'b0; e.acc_cyc = 0;
    if (sp) return e;
    for (int j = 0; j < DATA_W; j++) cw[pos_of(j)] = d[j];
    for (int i = 0; i < PAR_W - 1; i++) cw[1 << i] = p[i];
    cw[0] = p[PAR_W-1];
    for (int q = 1; q < 64; q++) if (cw[q]) s = s ^ q;
    o = ^cw;
    if (o) begin
      if (s > CW_TOP) e.ded = 1'b1;
      else begin
        e.sec = 1'b1;
        if (s != 0) cw[s] = ~cw[s];
        for (int j = 0; j < DATA_W; j++) e.data[j] = cw[pos_of(j)];
      end
    end else if (s != 0) e.ded = 1'b1;
`ifdef ECC_LOAD_POISON_EN
    if (e.ded) e.data = '1;
`endif
    return e;
  endfunction

  task automatic make_load(input int nflip, output logic [DATA_W-1:0] d,
                           output logic [PAR_W-1:0] p);
    int u[2];
    d = $urandom;
    p = encode(d);
    u[0] = $urandom_range(UNITS - 1, 0);
    u[1] = (u[0] + 1 + $urandom_range(UNITS - 2, 0)) % UNITS;
    for (int k = 0; k < nflip && k < 2; k++) begin
      if (u[k] < DATA_W) d[u[k]] = ~d[u[k]];
      else p[u[k] - DATA_W] = ~p[u[k] - DATA_W];
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: scoreboard responses, counters and stall stability at the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      sb.delete();
      m_sec = 0; m_ded = 0; stalled = 1'b0;
    end else begin
      chk("sec_count", 64'(sec_count), 64'(m_sec));
      chk("ded_count", 64'(ded_count), 64'(m_ded));
      if (stalled) begin
        chk("stall_valid", 64'(rsp_valid), 64'(1));
        chk("stall_data", 64'(rsp_data), 64'(held_data));
      end
      if (!req_ready) saw_not_ready = 1'b1;
      if (rsp_valid && rsp_ready) begin
        n_rsp++;
        if (sb.size() == 0) begin
          chk("unexpected_rsp", 64'(sb.size()), 64'(1));
        end else begin
          e = sb.pop_front();
          chk("rsp_data", 64'(rsp_data), 64'(e.data));
          chk("rsp_sec", 64'(rsp_sec), 64'(e.sec));
          chk("rsp_ded", 64'(rsp_ded), 64'(e.ded));
`ifdef ECC_LOAD_POISON_EN
          chk("rsp_poison", 64'(rsp_poison), 64'(e.ded));
`endif
          if (check_lat) chk("latency", 64'(cyc - e.acc_cyc), 64'(2));
          if (clr_cnt) begin m_sec = 0; m_ded = 0; end
          else begin
            if (e.sec && m_sec < 255) m_sec++;
            if (e.ded && m_ded < 255) m_ded++;
          end
        end
      end else if (clr_cnt) begin
        m_sec = 0; m_ded = 0;
      end
      stalled   = rsp_valid && !rsp_ready;
      held_data = rsp_data;
    end
  end

  // Present one load and wait (bounded) for acceptance; call at posedge+1.
  task automatic drive_req(input logic [DATA_W-1:0] d, input logic [PAR_W-1:0] p,
                           input logic sp);
    exp_t e;
    bit ok = 1'b0;
    req_valid = 1'b1; req_data = d; req_parity = p; req_special = sp;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (req_ready && rst_n) begin
        e = model(d, p, sp);
        e.acc_cyc = cyc;
        sb.push_back(e);
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("req_accept", 64'(req_ready), 64'(1));
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 500; k++) begin
      @(posedge clk);
      if (sb.size() == 0) break;
    end
    chk("drain", 64'(sb.size()), 64'(0));
    #1;
  endtask

  logic [DATA_W-1:0] w, d;
  logic [PAR_W-1:0]  p, pw;
  bit                done;

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_sec_count", 64'(sec_count), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'(1));
    @(posedge clk); #1;

    // Directed: zero word, single/double errors, special bypass, with latency checks
    check_lat = 1'b1;
    drive_req('0, '0, 1'b0); drain();
    w = 32'h1234_5678; pw = encode(w);
    drive_req(w ^ 32'h1, pw, 1'b0); drain();
    drive_req(w, pw ^ 7'h40, 1'b0); drain();
    drive_req(w, pw ^ 7'h04, 1'b0); drain();
    drive_req(w ^ 32'h3, pw, 1'b0); drain();
    drive_req(w ^ 32'h3, pw, 1'b1); drain();
    drive_req(32'hFFFF_FFFF, encode(32'hFFFF_FFFF), 1'b0); drain();
    check_lat = 1'b0;

    // Back-to-back stream with a 3-cycle stall on the second response
    saw_not_ready = 1'b0;
    fork
      begin
        for (int k = 0; k < 4; k++) begin
          make_load(1, d, p);
          drive_req(d, p, 1'b0);
        end
      end
      begin
        int base = n_rsp;
        for (int k = 0; k < 50; k++) begin
          @(posedge clk);
          if (n_rsp >= base + 1) break;
        end
        #1 rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rsp_ready = 1'b1;
      end
    join
    drain();
    chk("req_ready_drop", 64'(saw_not_ready), 64'(1));

    // Reset mid-stream discards in-flight loads
    make_load(1, d, p); drive_req(d, p, 1'b0);
    make_load(2, d, p); drive_req(d, p, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", 64'(rsp_valid), 64'(0));
    chk("mid_rst_sec", 64'(sec_count), 64'(0));
    chk("mid_rst_ded", 64'(ded_count), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_req_ready", 64'(req_ready), 64'(1));
    chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'(0));
    @(posedge clk); #1;

    // Randomized traffic with random backpressure and occasional counter clears
    done = 1'b0;
    fork
      begin
        for (int n = 0; n < 400; n++) begin
          int kind = $urandom_range(19, 0);
          if ($urandom_range(3, 0) == 0) begin @(posedge clk); #1; end
          if (kind < 8) make_load(0, d, p);
          else if (kind < 14) make_load(1, d, p);
          else if (kind < 17) make_load(2, d, p);
          else begin make_load(1, d, p); if (kind == 17) p = 7'($urandom); end
          drive_req(d, p, kind >= 18);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          rsp_ready = ($urandom_range(9, 0) < 7);
          clr_cnt   = ($urandom_range(49, 0) == 0);
        end
        rsp_ready = 1'b1;
        clr_cnt   = 1'b0;
      end
    join
    drain();

    // Saturation of the SEC counter
    for (int n = 0; n < 300; n++) begin
      make_load(1, d, p);
      drive_req(d, p, 1'b0);
    end
    drain();
    @(negedge clk);
    chk("sec_saturate", 64'(sec_count), 64'(255));
    @(posedge clk); #1;

    // Clear coinciding with a SEC handshake
    fork
      begin
        for (int n = 0; n < 10; n++) begin
          make_load(1, d, p);
          drive_req(d, p, 1'b0);
        end
      end
      begin
        repeat (5) @(posedge clk);
        #1 clr_cnt = 1'b1;
        @(posedge clk); #1 clr_cnt = 1'b0;
        @(negedge clk);
        chk("clr_priority", 64'(sec_count), 64'(0));
      end
    join
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
